// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//   Upstream issue stage for the single-precision fpu. Requests {op, a, b} are
//   buffered in a small FIFO and issued one at a time to the fpu, which has no
//   handshake and a registered output. The controller waits out the fpu
//   latency, captures dout and offers it on a valid/ready result port.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   FPU_LAT  fpu clock edges from operand sample to valid dout
//
// Ports
//   clk, rst                   clock and synchronous active-high reset
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_op          request operands and opcode (00 ADD 01 SUB 10 DIV 11 MUL)
//   fpu_a, fpu_b, fpu_opcode   registered drive to the fpu
//   fpu_dout                   fpu result
//   res_valid/res_ready        result handshake
//   res_data, res_op           captured result and its opcode
//   count                      FIFO occupancy
//   busy                       high when an op is in flight/held or the FIFO is not empty
//   res_flags (optional)       {nan, inf, zero} of res_data
//
// Build option
//   FPU_ISSUE_FLAGS_EN  when defined, adds res_flags[2:0].
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int FPU_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [1:0]               in_op,
  output logic [31:0]              fpu_a,
  output logic [31:0]              fpu_b,
  output logic [1:0]               fpu_opcode,
  input  logic [31:0]              fpu_dout,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [1:0]               res_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
`ifdef FPU_ISSUE_FLAGS_EN
  ,
  output logic [2:0]               res_flags
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(FPU_LAT + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [65:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_op;
  logic [31:0]       r_fpu_a;
  logic [31:0]       r_fpu_b;
  logic [1:0]        r_fpu_opcode;
  logic              r_res_valid;
  logic [31:0]       r_res_data;
  logic [1:0]        r_res_op;

  logic              w_push;
  logic              w_pop;
  logic [65:0]       w_head;

  // in_ready depends on registered count only, so there is no combinational
  // path from in_valid or res_ready to in_ready.
  assign in_ready = (r_count != CNT_W'(DEPTH));
  assign w_push   = in_valid & in_ready;
  // Only IDLE pops, and only from the registered count: an entry written at
  // one edge is visible for popping at the next edge at the earliest.
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];

  // NOTE: the storage array carries no reset; validity is tracked entirely by
  // the pointers and count, so resetting the data would only cost flops.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_op, in_a, in_b};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wait_cnt   <= '0;
      r_op         <= 2'b00;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_fpu_opcode <= 2'b00;
      r_res_valid  <= 1'b0;
      r_res_data   <= '0;
      r_res_op     <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_fpu_opcode <= w_head[65:64];
            r_fpu_a      <= w_head[63:32];
            r_fpu_b      <= w_head[31:0];
            r_op         <= w_head[65:64];
            r_wait_cnt   <= WAIT_W'(FPU_LAT);
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The fpu samples the operands one edge after the load; its dout is
          // valid FPU_LAT edges after that, i.e. when the counter hits zero.
          if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - 1'b1;
          if (r_wait_cnt <= WAIT_W'(1)) r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_res_data  <= fpu_dout;
          r_res_op    <= r_op;
          r_res_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        default: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef FPU_ISSUE_FLAGS_EN
  logic [2:0] r_res_flags;
  logic [2:0] w_dout_flags;

  always_comb begin
    w_dout_flags    = 3'b000;
    w_dout_flags[2] = (fpu_dout[30:23] == 8'hFF) && (fpu_dout[22:0] != '0);
    w_dout_flags[1] = (fpu_dout[30:23] == 8'hFF) && (fpu_dout[22:0] == '0);
    w_dout_flags[0] = (fpu_dout[30:23] == 8'h00) && (fpu_dout[22:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst)                      r_res_flags <= 3'b000;
    else if (r_state == S_CAPT)   r_res_flags <= w_dout_flags;
  end

  assign res_flags = r_res_flags;
`endif

  assign fpu_a      = r_fpu_a;
  assign fpu_b      = r_fpu_b;
  assign fpu_opcode = r_fpu_opcode;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_op     = r_res_op;
  assign count      = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
